// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

   typedef enum logic [1:0] {
      STATE_A       = 2'd0,
      STATE_COMMAND = 2'd1,
      STATE_B       = 2'd2,
      STATE_EQUAL   = 2'd3
   } statetype;

   typedef enum logic {
      C_ADD = 1'b0,
      C_SUB = 1'b1
   } commandtype;

   localparam logic [3:0] DIG_MINUS  = 4'hF;
   localparam logic [2:0] DIGS_RESET = 3'b001;

   // Operand increment with wrap back to zero past the maximum.
   function automatic logic [3:0] inc_operand(input logic [3:0] v, input logic [3:0] max_v);
      return (v >= max_v) ? 4'd0 : v + 4'd1;
   endfunction

endpackage

// File: rtl/calc_scan.sv
// Digit scan timer: holds each digit for SCAN_COUNT cycles, then rotates the
// one-hot select. digs_next lets the caller register data aligned with digs.
module calc_scan
   import calc_pkg::*;
#(
   parameter logic [31:0] SCAN_COUNT = 32'd25000
) (
   input  logic       sys_clk,
   input  logic       rst,
   output logic [2:0] digs,
   output logic [2:0] digs_next
);

   logic [31:0] cnt;
   logic        term;

   assign term = (cnt == SCAN_COUNT - 32'd1);

   // Rotate ones -> tens -> sign -> ones on terminal count.
   always_comb begin
      digs_next = term ? {digs[1:0], digs[2]} : digs;
   end

   // Scan counter and digit-select register.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         cnt  <= 32'd0;
         digs <= DIGS_RESET;
      end else begin
         cnt  <= term ? 32'd0 : cnt + 32'd1;
         digs <= digs_next;
      end
   end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: entry FSM, operand/command registers,
// ADD/SUB result and multiplexed three-digit display data.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter logic [31:0] SCAN_COUNT  = 32'd25000,
   parameter logic [3:0]  MAX_OPERAND = 4'd9
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       click_state,
   input  logic       click_inc,
   output logic [1:0] state,
   output logic [3:0] digit_val,
   output logic       digit_blank,
   output logic [2:0] digs
);

   statetype   state_q, state_d;
   commandtype cmd_q, cmd_d;
   logic [3:0] a_q, a_d, b_q, b_d;
   logic [2:0] digs_next;
   logic [5:0] r, mag;
   logic       tens;
   logic [3:0] ones;
   logic [3:0] val_d;
   logic       blank_d;

   calc_scan #(.SCAN_COUNT(SCAN_COUNT)) u_scan (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .digs      (digs),
      .digs_next (digs_next)
   );

   assign state = state_q;

   // State and operand registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= STATE_A;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         cmd_q   <= C_ADD;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cmd_q   <= cmd_d;
      end
   end

   // Next state and field edits; a state click swallows a same-cycle increment.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cmd_d   = cmd_q;
      if (click_state) begin
         case (state_q)
            STATE_A:       state_d = STATE_COMMAND;
            STATE_COMMAND: state_d = STATE_B;
            STATE_B:       state_d = STATE_EQUAL;
            STATE_EQUAL:   state_d = STATE_A;
            default:       state_d = STATE_A;
         endcase
      end else if (click_inc) begin
         case (state_q)
            STATE_A:       a_d   = inc_operand(a_q, MAX_OPERAND);
            STATE_COMMAND: cmd_d = (cmd_q == C_ADD) ? C_SUB : C_ADD;
            STATE_B:       b_d   = inc_operand(b_q, MAX_OPERAND);
            default:       ;
         endcase
      end
   end

   // Result as 6-bit two's complement; |r| <= 18 so a single compare splits digits.
   always_comb begin
      if (cmd_q == C_SUB) r = {2'b00, a_q} - {2'b00, b_q};
      else                r = {2'b00, a_q} + {2'b00, b_q};
      mag  = r[5] ? (6'd0 - r) : r;
      tens = (mag >= 6'd10);
      ones = tens ? (mag[3:0] - 4'd10) : mag[3:0];
   end

   // Content of the digit about to be selected.
   always_comb begin
      val_d   = 4'd0;
      blank_d = 1'b1;
      case (digs_next)
         3'b001: begin
            blank_d = 1'b0;
            case (state_q)
               STATE_A:       val_d = a_q;
               STATE_COMMAND: val_d = {3'b000, cmd_q};
               STATE_B:       val_d = b_q;
               default:       val_d = ones;
            endcase
         end
         3'b010: begin
            if (state_q == STATE_EQUAL) begin
               val_d   = {3'b000, tens};
               blank_d = !tens;
            end
         end
         3'b100: begin
            if (state_q == STATE_EQUAL && r[5]) begin
               val_d   = DIG_MINUS;
               blank_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Display data registered alongside digs so the pair switches together.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         digit_val   <= 4'd0;
         digit_blank <= 1'b0;
      end else begin
         digit_val   <= val_d;
         digit_blank <= blank_d;
      end
   end

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl with a short scan period.
module tb_calc_ctrl;

   localparam int SC = 4;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       click_state = 1'b0;
   logic       click_inc = 1'b0;
   logic [1:0] state;
   logic [3:0] digit_val;
   logic       digit_blank;
   logic [2:0] digs;

   int errors = 0;
   int checks = 0;
   int m_state, m_a, m_b, m_cmd;
   int edges = 0;

   always #5 sys_clk = ~sys_clk;

   calc_ctrl #(.SCAN_COUNT(32'd4), .MAX_OPERAND(4'd9)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .click_state (click_state),
      .click_inc   (click_inc),
      .state       (state),
      .digit_val   (digit_val),
      .digit_blank (digit_blank),
      .digs        (digs)
   );

   // Scan reference: clock edges seen since the last reset edge.
   always @(posedge sys_clk) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_reset;
      m_state = 0; m_a = 0; m_b = 0; m_cmd = 0;
   endtask

   task automatic do_reset;
      rst = 1'b1; click_state = 1'b0; click_inc = 1'b0;
      tick; tick;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic pulse(input logic s, input logic i, input string name);
      click_state = s; click_inc = i;
      tick;
      click_state = 1'b0; click_inc = 1'b0;
      if (s) m_state = (m_state + 1) % 4;
      else if (i) begin
         case (m_state)
            0: m_a = (m_a >= 9) ? 0 : m_a + 1;
            1: m_cmd = 1 - m_cmd;
            2: m_b = (m_b >= 9) ? 0 : m_b + 1;
            default: ;
         endcase
      end
      checks++;
      if (state !== 2'(m_state)) begin
         errors++;
         $display("FAIL %s state: got %0d want %0d", name, state, m_state);
      end
   endtask

   task automatic exp_digit(input int slot, output logic [3:0] v, output logic b);
      int r, mag;
      r   = m_cmd ? (m_a - m_b) : (m_a + m_b);
      mag = (r < 0) ? -r : r;
      v = 4'd0; b = 1'b1;
      if (slot == 0) begin
         b = 1'b0;
         case (m_state)
            0: v = 4'(m_a);
            1: v = 4'(m_cmd);
            2: v = 4'(m_b);
            default: v = 4'(mag % 10);
         endcase
      end else if (slot == 1) begin
         if (m_state == 3 && mag >= 10) begin v = 4'(mag / 10); b = 1'b0; end
      end else begin
         if (m_state == 3 && r < 0) begin v = 4'hF; b = 1'b0; end
      end
   endtask

   task automatic check_display(input string name);
      logic [3:0] ev;
      logic       eb;
      tick; tick;
      for (int slot = 0; slot < 3; slot++) begin
         int n = 0;
         while (digs !== 3'(1 << slot) && n < 20) begin tick; n++; end
         checks++;
         if (n >= 20) begin
            errors++;
            $display("FAIL %s slot%0d timeout: digs=%b never reached %b", name, slot, digs, 3'(1 << slot));
         end else begin
            if (digs !== 3'(1 << ((edges / SC) % 3))) begin
               errors++;
               $display("FAIL %s scan phase: digs=%b at edge %0d", name, digs, edges);
            end
            exp_digit(slot, ev, eb);
            checks++;
            if (digit_blank !== eb) begin
               errors++;
               $display("FAIL %s slot%0d blank: got %b want %b", name, slot, digit_blank, eb);
            end
            if (!eb) begin
               checks++;
               if (digit_val !== ev) begin
                  errors++;
                  $display("FAIL %s slot%0d val: got %h want %h", name, slot, digit_val, ev);
               end
            end
         end
      end
   endtask

   task automatic test_reset;
      do_reset();
      rst = 1'b1; tick; tick;
      checks += 4;
      if (state !== 2'd0) begin errors++; $display("FAIL reset state: got %0d want 0", state); end
      if (digs !== 3'b001) begin errors++; $display("FAIL reset digs: got %b want 001", digs); end
      if (digit_val !== 4'd0) begin errors++; $display("FAIL reset digit_val: got %h want 0", digit_val); end
      if (digit_blank !== 1'b0) begin errors++; $display("FAIL reset digit_blank: got %b want 0", digit_blank); end
      rst = 1'b0;
      model_reset();
      for (int i = 1; i <= 4; i++) begin
         tick;
         if (i == 3) begin
            checks++;
            if (digs !== 3'b001) begin errors++; $display("FAIL reset scan hold: got %b want 001", digs); end
         end
         if (i == 4) begin
            checks++;
            if (digs !== 3'b010) begin errors++; $display("FAIL reset scan advance: got %b want 010", digs); end
         end
      end
   endtask

   task automatic test_wrap;
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         pulse(1'b0, 1'b1, "wrap_inc");
         if (i == 9) check_display("wrap_nine");
      end
      check_display("wrap_zero");
   endtask

   task automatic test_sub;
      do_reset();
      repeat (3) pulse(1'b0, 1'b1, "sub_a");
      pulse(1'b1, 1'b0, "sub_to_cmd");
      pulse(1'b0, 1'b1, "sub_toggle");
      check_display("sub_cmd");
      pulse(1'b1, 1'b0, "sub_to_b");
      repeat (7) pulse(1'b0, 1'b1, "sub_b");
      pulse(1'b1, 1'b0, "sub_to_eq");
      check_display("sub_eq");
   endtask

   task automatic test_add;
      do_reset();
      repeat (9) pulse(1'b0, 1'b1, "add_a");
      pulse(1'b1, 1'b0, "add_to_cmd");
      pulse(1'b1, 1'b0, "add_to_b");
      repeat (9) pulse(1'b0, 1'b1, "add_b");
      pulse(1'b1, 1'b0, "add_to_eq");
      check_display("add_eq");
   endtask

   task automatic test_collision_guard;
      do_reset();
      repeat (2) pulse(1'b0, 1'b1, "coll_a");
      pulse(1'b1, 1'b1, "collide");
      check_display("collide_cmd");
      pulse(1'b1, 1'b0, "coll_to_b");
      pulse(1'b1, 1'b0, "coll_to_eq");
      check_display("collide_eq");
      repeat (3) pulse(1'b0, 1'b1, "guard_inc");
      check_display("guard_eq");
   endtask

   task automatic test_mid_reset;
      int n = 0;
      while (digs !== 3'b100 && n < 20) begin tick; n++; end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL midrst wait: digs=%b never reached 100", digs); end
      rst = 1'b1; click_inc = 1'b1;
      tick;
      rst = 1'b0; click_inc = 1'b0;
      model_reset();
      checks += 4;
      if (state !== 2'd0) begin errors++; $display("FAIL midrst state: got %0d want 0", state); end
      if (digs !== 3'b001) begin errors++; $display("FAIL midrst digs: got %b want 001", digs); end
      if (digit_val !== 4'd0) begin errors++; $display("FAIL midrst digit_val: got %h want 0", digit_val); end
      if (digit_blank !== 1'b0) begin errors++; $display("FAIL midrst digit_blank: got %b want 0", digit_blank); end
      check_display("midrst_after");
   endtask

   task automatic test_random;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         pulse(($urandom_range(3) == 0), ($urandom_range(1) == 1), "rand_step");
         if (i % 10 == 9) check_display("rand_disp");
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_sub();
      test_add();
      test_collision_guard();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
